// File: rtl/eig_iter_controller.sv
// rtl/eig_iter_controller.sv - iteration sequencer for the 4x4 eigenvalue engine
// Optional iteration cap enabled by defining EIG_ITER_LIMIT_EN.
module eig_iter_controller #(
  parameter int TOL      = 1,
  parameter int MAX_ITER = 64,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [255:0]     in_matrix,
  output logic             in_ready,
  output logic             eng_start,
  output logic [255:0]     eng_a,
  input  logic             eng_done,
  input  logic [255:0]     eng_a_next,
  output logic             ev_valid,
  output logic [15:0]      ev_data,
  output logic             ev_last,
  input  logic             ev_ready,
  output logic             busy,
  output logic [CNT_W-1:0] iter_count,
  output logic             timeout
);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_EMIT} state_t;

  localparam logic signed [15:0] TOL_P = 16'(TOL);
  localparam logic signed [15:0] TOL_N = 16'(-TOL);

  state_t             state_q, state_d;
  logic [255:0]       a_cur_q, a_cur_d;
  logic [CNT_W-1:0]   iter_q, iter_d;
  logic [1:0]         k_q, k_d;
  logic               conv;
  logic               limit_hit;

  function automatic logic [15:0] elem(input logic [255:0] m, input int r, input int c);
    return m[16*(4*r+c) +: 16];
  endfunction

  function automatic logic near_zero(input logic [15:0] x);
    return ($signed(x) >= TOL_N) && ($signed(x) <= TOL_P);
  endfunction

  assign conv = near_zero(elem(a_cur_q, 1, 0)) && near_zero(elem(a_cur_q, 2, 0)) &&
                near_zero(elem(a_cur_q, 2, 1)) && near_zero(elem(a_cur_q, 3, 0)) &&
                near_zero(elem(a_cur_q, 3, 1)) && near_zero(elem(a_cur_q, 3, 2));

`ifdef EIG_ITER_LIMIT_EN
  logic timeout_q, timeout_d;

  assign limit_hit = (iter_q == CNT_W'(MAX_ITER));

  always_comb begin
    timeout_d = timeout_q;
    if (state_q == S_IDLE && in_valid) begin
      timeout_d = 1'b0;
    end else if (state_q == S_CHECK && !conv && limit_hit) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign limit_hit = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    a_cur_d = a_cur_q;
    iter_d  = iter_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_cur_d = in_matrix;
          iter_d  = '0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        k_d = 2'd0;
        // A capped run still drains whatever diagonal it reached.
        if (conv || limit_hit) begin
          state_d = S_EMIT;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (eng_done) begin
          a_cur_d = eng_a_next;
          iter_d  = (iter_q == '1) ? iter_q : iter_q + 1'b1;
          state_d = S_CHECK;
        end
      end
      S_EMIT: begin
        if (ev_ready) begin
          k_d = k_q + 2'd1;
          if (k_q == 2'd3) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_cur_q <= '0;
      iter_q  <= '0;
      k_q     <= 2'd0;
    end else begin
      state_q <= state_d;
      a_cur_q <= a_cur_d;
      iter_q  <= iter_d;
      k_q     <= k_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign eng_start  = (state_q == S_ISSUE);
  assign eng_a      = a_cur_q;
  assign ev_valid   = (state_q == S_EMIT);
  assign ev_last    = (state_q == S_EMIT) && (k_q == 2'd3);
  assign ev_data    = (state_q == S_EMIT) ? elem(a_cur_q, int'(k_q), int'(k_q)) : 16'h0000;
  assign iter_count = iter_q;

endmodule

// File: tb/tb_eig_iter_controller.sv
// tb/tb_eig_iter_controller.sv - scoreboard bench for eig_iter_controller
module tb_eig_iter_controller;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [255:0] in_matrix = '0;
  logic         in_ready;
  logic         eng_start;
  logic [255:0] eng_a;
  logic         eng_done = 1'b0;
  logic [255:0] eng_a_next = '0;
  logic         ev_valid;
  logic [15:0]  ev_data;
  logic         ev_last;
  logic         ev_ready = 1'b1;
  logic         busy;
  logic [7:0]   iter_count;
  logic         timeout;

  eig_iter_controller #(.TOL(1), .MAX_ITER(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_matrix(in_matrix),
    .in_ready(in_ready), .eng_start(eng_start), .eng_a(eng_a), .eng_done(eng_done),
    .eng_a_next(eng_a_next), .ev_valid(ev_valid), .ev_data(ev_data), .ev_last(ev_last),
    .ev_ready(ev_ready), .busy(busy), .iter_count(iter_count), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [16:0]  exp_q[$];
  int           start_cnt = 0;
  int           conv_after = 0;
  logic         eng_hold = 1'b0;
  logic         force_done = 1'b0;
  logic         use_pat = 1'b0;
  int           pidx = 0;
  logic         pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [255:0] eng_exp_a = '0;
  logic [255:0] res_diag;
  logic [255:0] res_nonconv;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] put(input logic [255:0] m, input int r, input int c,
                                       input logic [15:0] v);
    logic [255:0] t;
    t = m;
    t[16*(4*r+c) +: 16] = v;
    return t;
  endfunction

  function automatic logic [255:0] diag4(input logic [15:0] a, input logic [15:0] b,
                                         input logic [15:0] c, input logic [15:0] d);
    logic [255:0] t;
    t = '0;
    t = put(t, 0, 0, a);
    t = put(t, 1, 1, b);
    t = put(t, 2, 2, c);
    t = put(t, 3, 3, d);
    return t;
  endfunction

  task automatic push4(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] d);
    exp_q.push_back({1'b0, a});
    exp_q.push_back({1'b0, b});
    exp_q.push_back({1'b0, c});
    exp_q.push_back({1'b1, d});
  endtask

  // Output monitor: pops the scoreboard on every accepted eigenvalue.
  logic        stalled = 1'b0;
  logic [15:0] held = '0;
  initial forever begin
    logic [16:0] e;
    @(negedge clk);
    if (rst_n && ev_valid) begin
      if (stalled) chk("ev_hold", ev_data, held);
      if (ev_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL ev_unexpected: got %0h expected no output", ev_data);
        end else begin
          e = exp_q.pop_front();
          chk("ev_data", ev_data, e[15:0]);
          chk("ev_last", ev_last, e[16]);
        end
      end
      stalled = !ev_ready;
      held    = ev_data;
    end else begin
      stalled = 1'b0;
    end
  end

  // Engine model: fixed two-cycle latency, converges on the conv_after-th start.
  initial forever begin
    @(negedge clk);
    if (force_done) begin
      eng_done   = 1'b1;
      eng_a_next = res_diag;
      @(negedge clk);
      eng_done   = 1'b0;
      force_done = 1'b0;
    end else if (eng_start) begin
      start_cnt++;
      chk("eng_a", eng_a, eng_exp_a);
      if (!eng_hold) begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        eng_done   = 1'b1;
        eng_a_next = (conv_after != 0 && start_cnt >= conv_after) ? res_diag : res_nonconv;
        eng_exp_a  = eng_a_next;
        @(posedge clk); #1;
        eng_done   = 1'b0;
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (!use_pat) begin
      ev_ready = 1'b1;
    end else if (ev_valid) begin
      ev_ready = pat[pidx];
      pidx = (pidx + 1) % 4;
    end
  end

  task automatic load(input logic [255:0] m);
    int i;
    i = 0;
    start_cnt = 0;
    eng_exp_a = m;
    @(posedge clk); #1;
    in_valid  = 1'b1;
    in_matrix = m;
    while (!in_ready && i < 50) begin
      @(posedge clk); #1;
      i++;
    end
    if (i >= 50) begin
      n_cmp++; n_err++;
      $display("FAIL load_timeout: got in_ready=0 expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run(input string nm, input logic [255:0] m, input int exp_starts,
                     input int exp_iter, input logic exp_to);
    int i;
    load(m);
    i = 0;
    while (busy && i < 500) begin
      @(posedge clk); #1;
      i++;
    end
    if (i >= 500) begin
      n_cmp++; n_err++;
      $display("FAIL %s_idle_timeout: got busy=1 expected 0", nm);
    end
    @(negedge clk);
    chk({nm, "_starts"}, start_cnt, exp_starts);
    chk({nm, "_iter"}, iter_count, exp_iter);
    chk({nm, "_timeout"}, timeout, exp_to);
    chk({nm, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    logic [255:0] m;
    int i;
    res_diag    = diag4(16'd5, 16'd6, 16'd7, 16'd8);
    res_nonconv = put(diag4(16'h0011, 16'h0022, 16'h0033, 16'h0044), 2, 1, 16'h0100);

    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_eng_start", eng_start, 1'b0);
    chk("rst_ev_valid", ev_valid, 1'b0);
    chk("rst_ev_last", ev_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_iter", iter_count, 8'd0);
    chk("rst_ev_data", ev_data, 16'd0);
    chk("rst_eng_a", eng_a, 256'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    push4(16'h0100, 16'h0200, 16'h0300, 16'h0400);
    run("diag", diag4(16'h0100, 16'h0200, 16'h0300, 16'h0400), 0, 0, 1'b0);

    m = put(put(diag4(16'd1, 16'd2, 16'd3, 16'd4), 3, 1, 16'hFFFF), 0, 1, 16'h7777);
    push4(16'd1, 16'd2, 16'd3, 16'd4);
    run("tol_in", m, 0, 0, 1'b0);

    conv_after = 1;
    m = put(put(diag4(16'd1, 16'd2, 16'd3, 16'd4), 3, 1, 16'hFFFE), 0, 1, 16'h7777);
    push4(16'd5, 16'd6, 16'd7, 16'd8);
    run("tol_out", m, 1, 1, 1'b0);

    conv_after = 3;
    m = put(diag4(16'd9, 16'd9, 16'd9, 16'd9), 1, 0, 16'h0002);
    push4(16'd5, 16'd6, 16'd7, 16'd8);
    run("iter3", m, 3, 3, 1'b0);

`ifdef EIG_ITER_LIMIT_EN
    conv_after = 0;
    push4(16'h0011, 16'h0022, 16'h0033, 16'h0044);
    run("limit", m, 4, 4, 1'b1);
`endif

    use_pat = 1'b1;
    pidx = 0;
    push4(16'h0A0B, 16'h8001, 16'h7FFF, 16'h1234);
    run("stall", diag4(16'h0A0B, 16'h8001, 16'h7FFF, 16'h1234), 0, 0, 1'b0);
    use_pat = 1'b0;

    eng_hold = 1'b1;
    load(m);
    i = 0;
    while (start_cnt == 0 && i < 50) begin
      @(posedge clk); #1;
      i++;
    end
    chk("abort_started", start_cnt, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_in_ready", in_ready, 1'b1);
    chk("abort_eng_a", eng_a, 256'd0);
    chk("abort_iter", iter_count, 8'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    force_done = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("post_ev_valid", ev_valid, 1'b0);
      chk("post_busy", busy, 1'b0);
      chk("post_eng_start", eng_start, 1'b0);
      chk("post_in_ready", in_ready, 1'b1);
      chk("post_iter", iter_count, 8'd0);
    end
    chk("post_sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
